// File: rtl/mac_params.sv
// Shared MAC parameters, types and CRC helpers for the TX path.
package mac_params;

  localparam int N_SYMBOLS = 4;
  localparam int W_SYMBOL  = 8;
  localparam int W_CRC     = 32;
  localparam int FCS_BYTES = 4;

  // Reflected IEEE 802.3 polynomial and preset value of the running CRC.
  localparam logic [W_CRC-1:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [W_CRC-1:0] CRC_RESET = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    TX_DATA = 1'b0,
    TX_TAIL = 1'b1
  } tx_state_e;

  // One word of byte lanes; lane 0 is the first byte on the wire.
  typedef logic [N_SYMBOLS-1:0][W_SYMBOL-1:0] lane_data_t;

  // Advance a reflected CRC-32 register by one byte, LSB first.
  function automatic logic [W_CRC-1:0] crc32_byte(input logic [W_CRC-1:0] crc_in,
                                                  input logic [W_SYMBOL-1:0] data_in);
    logic [W_CRC-1:0] c;
    c = crc_in ^ {24'h00_0000, data_in};
    for (int b = 0; b < W_SYMBOL; b++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Byte enables must be contiguous from lane 0; partial words only on the last word.
  function automatic logic keep_legal(input logic [N_SYMBOLS-1:0] keep,
                                      input logic last);
    logic ok;
    case (keep)
      4'b1111:                   ok = 1'b1;
      4'b0001, 4'b0011, 4'b0111: ok = last;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mac_crc32.sv
// Running Ethernet CRC-32 over up to N_SYMBOLS contiguous byte lanes per cycle.
// o_crc is the finished (inverted) value; FCS byte k is o_crc[8k+7:8k].
module mac_crc32
  import mac_params::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic [N_SYMBOLS-1:0] i_en,
  input  lane_data_t           i_data,
  input  logic                 i_clr,
  output logic [W_CRC-1:0]     o_crc
);

  logic [W_CRC-1:0] crc_q;
  logic [W_CRC-1:0] crc_d;

  // Fold the enabled lanes into the CRC in wire order; clear wins over data.
  always_comb begin
    crc_d = crc_q;
    if (i_clr) begin
      crc_d = CRC_RESET;
    end else begin
      for (int i = 0; i < N_SYMBOLS; i++) begin
        if (i_en[i]) begin
          crc_d = crc32_byte(crc_d, i_data[i]);
        end else begin
          crc_d = crc_d;
        end
      end
    end
  end

  // CRC register, advancing only on enabled gearbox cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_q <= CRC_RESET;
    end else if (i_clk_en) begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = ~crc_q;

endmodule

// File: rtl/mac_tx_fcs_inserter.sv
// TX FCS inserter: passes payload through a one-word stage and appends the
// lane-packed 4-byte FCS right after the last payload byte. When the last
// word is full the FCS becomes a whole extra beat; otherwise it straddles
// the last payload beat and a tail beat.
module mac_tx_fcs_inserter
  import mac_params::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  lane_data_t           i_data,
  input  logic [N_SYMBOLS-1:0] i_keep,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output lane_data_t           o_data,
  output logic [N_SYMBOLS-1:0] o_keep,
  output logic                 o_last
);

  // Number of valid payload lanes in a contiguous keep mask.
  function automatic int keep_count(input logic [N_SYMBOLS-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N_SYMBOLS; i++) begin
      cnt = cnt + int'(keep[i]);
    end
    return cnt;
  endfunction

  // Last payload beat: n payload lanes, then the leading FCS bytes.
  function automatic lane_data_t merge_last(input lane_data_t d,
                                            input int n,
                                            input logic [W_CRC-1:0] crc);
    lane_data_t r;
    for (int i = 0; i < N_SYMBOLS; i++) begin
      if (i < n) begin
        r[i] = d[i];
      end else begin
        r[i] = W_SYMBOL'(crc >> (W_SYMBOL * (i - n)));
      end
    end
    return r;
  endfunction

  // Tail beat: the FCS bytes that did not fit, lanes beyond them zeroed.
  function automatic lane_data_t merge_tail(input int n,
                                            input logic [W_CRC-1:0] crc);
    lane_data_t r;
    for (int i = 0; i < N_SYMBOLS; i++) begin
      if (i < n) begin
        r[i] = W_SYMBOL'(crc >> (W_SYMBOL * (FCS_BYTES - n + i)));
      end else begin
        r[i] = '0;
      end
    end
    return r;
  endfunction

  tx_state_e            state_q, state_d;
  lane_data_t           s_data_q, s_data_d;
  logic [N_SYMBOLS-1:0] s_keep_q, s_keep_d;
  logic                 s_last_q, s_last_d;
  logic                 s_valid_q, s_valid_d;

  logic                 accept_s;
  logic                 xfer_s;
  logic                 crc_clr_s;
  logic [N_SYMBOLS-1:0] crc_en_s;
  logic [W_CRC-1:0]     crc_s;
  int                   n_s;

  // The stage never accepts behind a last word or during the tail, so the
  // CRC clear at the tail transfer cannot collide with the next frame's data.
  assign o_ready  = ~i_reset & i_clk_en & (state_q == TX_DATA) &
                    (~s_valid_q | (i_ready & ~s_last_q));
  assign accept_s = i_valid & o_ready;
  assign xfer_s   = o_valid & i_ready & i_clk_en;
  assign crc_en_s = accept_s ? i_keep : {N_SYMBOLS{1'b0}};
  assign n_s      = keep_count(s_keep_q);

  mac_crc32 u_crc (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clk_en (i_clk_en),
    .i_en     (crc_en_s),
    .i_data   (i_data),
    .i_clr    (crc_clr_s),
    .o_crc    (crc_s)
  );

  // Output beat decode from the stage, the state and the finished CRC.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_keep  = '0;
    o_last  = 1'b0;
    case (state_q)
      TX_DATA: begin
        if (s_valid_q) begin
          o_valid = 1'b1;
          if (s_last_q) begin
            o_data = merge_last(s_data_q, n_s, crc_s);
            o_keep = {N_SYMBOLS{1'b1}};
          end else begin
            o_data = s_data_q;
            o_keep = s_keep_q;
          end
        end else begin
          o_valid = 1'b0;
        end
      end
      TX_TAIL: begin
        o_valid = 1'b1;
        o_data  = merge_tail(n_s, crc_s);
        o_keep  = s_keep_q;
        o_last  = 1'b1;
      end
      default: begin
        o_valid = 1'b0;
      end
    endcase
  end

  // Next-state for the stage and the DATA/TAIL sequencing.
  always_comb begin
    state_d   = state_q;
    s_data_d  = s_data_q;
    s_keep_d  = s_keep_q;
    s_last_d  = s_last_q;
    s_valid_d = s_valid_q;
    crc_clr_s = 1'b0;
    case (state_q)
      TX_DATA: begin
        if (xfer_s) begin
          s_valid_d = 1'b0;
          if (s_last_q) begin
            state_d = TX_TAIL;
          end else begin
            state_d = TX_DATA;
          end
        end else begin
          state_d = TX_DATA;
        end
        if (accept_s) begin
          s_valid_d = 1'b1;
          s_data_d  = i_data;
          s_keep_d  = i_keep;
          s_last_d  = i_last;
        end else begin
          s_data_d  = s_data_q;
        end
      end
      TX_TAIL: begin
        if (xfer_s) begin
          state_d   = TX_DATA;
          crc_clr_s = 1'b1;
        end else begin
          state_d   = TX_TAIL;
        end
      end
      default: begin
        state_d = TX_DATA;
      end
    endcase
  end

  // State and stage registers; keep stays latched through the tail.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= TX_DATA;
      s_data_q  <= '0;
      s_keep_q  <= '0;
      s_last_q  <= 1'b0;
      s_valid_q <= 1'b0;
    end else if (i_clk_en) begin
      state_q   <= state_d;
      s_data_q  <= s_data_d;
      s_keep_q  <= s_keep_d;
      s_last_q  <= s_last_d;
      s_valid_q <= s_valid_d;
    end
  end

`ifndef SYNTHESIS
  // Catch malformed byte enables on accepted words.
  always @(posedge i_clk) begin
    if (!i_reset && accept_s && !keep_legal(i_keep, i_last)) begin
      $fatal(1, "mac_tx_fcs_inserter: illegal i_keep %b (i_last=%b)", i_keep, i_last);
    end
  end
`endif

endmodule

// File: tb/tb_mac_tx_fcs_inserter.sv
// Directed bench for mac_tx_fcs_inserter: frames are described as byte
// streams, the expected output is the stream plus FCS re-chunked into words.
module tb_mac_tx_fcs_inserter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_clk_en;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic [3:0]  i_keep;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last;

  int checks   = 0;
  int failures = 0;

  beat_t in_q[$];
  beat_t exp_q[$];
  beat_t out_q[$];
  beat_t ref_q[$];
  int    beat_cyc[$];
  int    frame_beats[$];
  bit    timed_out;
  int    rdy_viol;

  mac_tx_fcs_inserter dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clk_en (i_clk_en),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_keep   (i_keep),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_keep   (o_keep),
    .o_last   (o_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic clear_queues();
    in_q.delete();
    exp_q.delete();
    out_q.delete();
    beat_cyc.delete();
    frame_beats.delete();
  endtask

  // Append one frame: input words, and expected beats from a bitwise CRC model.
  task automatic load_frame(input int len, input logic [7:0] base, input logic [7:0] step);
    logic [7:0]  b[$];
    logic [31:0] c;
    beat_t       w;
    int          nb;
    for (int i = 0; i < len; i++) b.push_back(8'(base + 8'(i) * step));
    for (int i = 0; i < len; i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < len) begin
          w.data[8*j +: 8] = b[i+j];
          w.keep[j] = 1'b1;
        end
      end
      w.last = (i + 4 >= len);
      in_q.push_back(w);
    end
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
    nb = 0;
    for (int i = 0; i < len + 4; i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < len + 4) begin
          w.data[8*j +: 8] = b[i+j];
          w.keep[j] = 1'b1;
        end
      end
      w.last = (i + 4 >= len + 4);
      exp_q.push_back(w);
      nb++;
    end
    frame_beats.push_back(nb);
  endtask

  // Stream in_q into the DUT and capture transferred beats; entered and left at posedge+1.
  task automatic run(input bit stall, input int max_cyc);
    int wi;
    int cyc;
    wi = 0;
    cyc = 0;
    rdy_viol = 0;
    out_q.delete();
    beat_cyc.delete();
    while (out_q.size() < exp_q.size() && cyc < max_cyc) begin
      i_clk_en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_ready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (wi < in_q.size()) begin
        i_valid = 1'b1;
        i_data  = in_q[wi].data;
        i_keep  = in_q[wi].keep;
        i_last  = in_q[wi].last;
      end else begin
        i_valid = 1'b0;
        i_data  = 32'h0;
        i_keep  = 4'h0;
        i_last  = 1'b0;
      end
      @(negedge i_clk);
      if (!i_clk_en && o_ready) rdy_viol++;
      if (i_clk_en && o_valid && i_ready) begin
        out_q.push_back({o_data, o_keep, o_last});
        beat_cyc.push_back(cyc);
      end
      if (i_valid && o_ready) wi++;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    timed_out = (out_q.size() < exp_q.size());
    i_valid  = 1'b0;
    i_clk_en = 1'b1;
    i_ready  = 1'b1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_clk_en = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_data = 32'h0; i_keep = 4'h0; i_last = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_valid, o_ready, o_keep, o_last, o_data} !== 39'h0) begin
      failures++;
      $display("FAIL reset_state got valid=%b ready=%b keep=%b last=%b data=%h want all zero",
               o_valid, o_ready, o_keep, o_last, o_data);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got valid=%b ready=%b want valid=0 ready=1", o_valid, o_ready);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_check_string();
    clear_queues();
    load_frame(9, 8'h31, 8'h01);
    run(1'b0, 100);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL crc123_timeout got %0d beats want %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL crc123_beat%0d got %h/%b/%b want %h/%b/%b", i, out_q[i].data,
                 out_q[i].keep, out_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    if (out_q.size() == 4) begin
      checks++;
      if (out_q[2] !== {32'hF439_2639, 4'b1111, 1'b0}) begin
        failures++;
        $display("FAIL crc123_merge got %h/%b/%b want F4392639/1111/0", out_q[2].data,
                 out_q[2].keep, out_q[2].last);
      end
      checks++;
      if (out_q[3] !== {32'h0000_00CB, 4'b0001, 1'b1}) begin
        failures++;
        $display("FAIL crc123_tail got %h/%b/%b want 000000CB/0001/1", out_q[3].data,
                 out_q[3].keep, out_q[3].last);
      end
    end else begin
      checks++;
      failures++;
      $display("FAIL crc123_count got %0d beats want 4", out_q.size());
    end
  endtask

  task automatic test_partial_keep(input int len);
    clear_queues();
    load_frame(len, 8'h01, 8'h01);
    run(1'b0, 100);
    checks++;
    if (timed_out || out_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL keep_len%0d_count got %0d beats want %0d", len, out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL keep_len%0d_beat%0d got %h/%b/%b want %h/%b/%b", len, i, out_q[i].data,
                 out_q[i].keep, out_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  task automatic test_stalls();
    clear_queues();
    load_frame(64, 8'hA5, 8'h3B);
    run(1'b0, 200);
    ref_q = out_q;
    run(1'b1, 2000);
    checks++;
    if (timed_out || out_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stall_count got %0d beats want %0d", out_q.size(), exp_q.size());
    end
    checks++;
    if (rdy_viol != 0) begin
      failures++;
      $display("FAIL stall_ready_gated got %0d ready-while-disabled cycles want 0", rdy_viol);
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i] || (i < ref_q.size() && ref_q[i] !== exp_q[i])) begin
        failures++;
        $display("FAIL stall_beat%0d got %h/%b/%b want %h/%b/%b", i, out_q[i].data,
                 out_q[i].keep, out_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_queues();
    load_frame(12, 8'h10, 8'h11);
    load_frame(9, 8'h31, 8'h01);
    run(1'b0, 200);
    checks++;
    if (timed_out || out_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count got %0d beats want %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_beat%0d got %h/%b/%b want %h/%b/%b", i, out_q[i].data,
                 out_q[i].keep, out_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    if (beat_cyc.size() > frame_beats[0]) begin
      gap = beat_cyc[frame_beats[0]] - beat_cyc[frame_beats[0] - 1];
      checks++;
      if (gap != 2) begin
        failures++;
        $display("FAIL b2b_bubble got gap %0d cycles want 2 (one empty beat)", gap);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    i_clk_en = 1'b1; i_ready = 1'b1; i_valid = 1'b1;
    i_keep = 4'hF; i_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_data = 32'h1122_3344 + 32'(k);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_keep !== 4'h0) begin
      failures++;
      $display("FAIL midreset_outputs got valid=%b last=%b keep=%b want 0/0/0000",
               o_valid, o_last, o_keep);
    end
    @(posedge i_clk); #1;
    clear_queues();
    load_frame(14, 8'h5A, 8'h0D);
    run(1'b0, 100);
    checks++;
    if (timed_out || out_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midreset_count got %0d beats want %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midreset_beat%0d got %h/%b/%b want %h/%b/%b", i, out_q[i].data,
                 out_q[i].keep, out_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_partial_keep(8);
    test_partial_keep(10);
    test_partial_keep(11);
    test_stalls();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
